// File: rtl/tmds_encoder.sv
// TMDS 8b/10b encoder for one DVI colour channel.
// Stage 1 minimises transitions (XOR/XNOR chain into q_m); stage 2 applies
// DC balancing against a running disparity and emits the 10-bit symbol.
// Control periods emit one of four fixed codes and clear the disparity so
// every active line starts balanced.
module tmds_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       de,
    input  logic [7:0] data,
    input  logic [1:0] ctrl,
    output logic [9:0] symbol,
    output logic       de_q
);

    // Stage 1 registers
    logic [8:0]        q_m_q, q_m_d;
    logic              de_s1_q;
    logic [1:0]        ctrl_s1_q;

    // Stage 2 registers
    logic [9:0]        symbol_q, symbol_d;
    logic              de_s2_q;
    logic signed [4:0] cnt_q, cnt_d;

    // Stage 1 helpers
    logic [3:0]        n1_data;
    logic              use_xnor;

    // Stage 2 helpers
    logic [3:0]        n1_qm;
    logic [3:0]        n0_qm;
    logic signed [4:0] qm_diff;   // N1q - N0q, counts zero-extended (8 must stay +8)

    // Stage 1: pick XOR or XNOR chaining to minimise transitions in q_m
    always_comb begin
        n1_data = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1_data = n1_data + {3'b000, data[i]};
        end
        use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data[0]);
        q_m_d    = 9'd0;
        q_m_d[0] = data[0];
        for (int i = 1; i < 8; i++) begin
            q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ data[i]) : (q_m_d[i-1] ^ data[i]);
        end
        q_m_d[8] = ~use_xnor;
    end

    // Stage 1 pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_m_q     <= 9'd0;
            de_s1_q   <= 1'b0;
            ctrl_s1_q <= 2'b00;
        end else begin
            q_m_q     <= q_m_d;
            de_s1_q   <= de;
            ctrl_s1_q <= ctrl;
        end
    end

    // Stage 2 helpers: ones/zeros balance of the intermediate byte
    always_comb begin
        n1_qm = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n1_qm = n1_qm + {3'b000, q_m_q[i]};
        end
        n0_qm   = 4'd8 - n1_qm;
        qm_diff = $signed({1'b0, n1_qm}) - $signed({1'b0, n0_qm});
    end

    // Stage 2: DC balancing decision and disparity update
    always_comb begin
        symbol_d = 10'h354;
        cnt_d    = cnt_q;
        if (!de_s1_q) begin
            case (ctrl_s1_q)
                2'b00:   symbol_d = 10'h354;
                2'b01:   symbol_d = 10'h0AB;
                2'b10:   symbol_d = 10'h154;
                default: symbol_d = 10'h2AB;
            endcase
            cnt_d = 5'sd0;
        end else if ((cnt_q == 5'sd0) || (n1_qm == n0_qm)) begin
            symbol_d = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
            cnt_d    = q_m_q[8] ? (cnt_q + qm_diff) : (cnt_q - qm_diff);
        end else if ((!cnt_q[4] && (n1_qm > n0_qm)) || (cnt_q[4] && (n0_qm > n1_qm))) begin
            // cnt_q is nonzero here, so a clear sign bit means strictly positive
            symbol_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
            cnt_d    = cnt_q + (q_m_q[8] ? 5'sd2 : 5'sd0) - qm_diff;
        end else begin
            symbol_d = {1'b0, q_m_q[8], q_m_q[7:0]};
            cnt_d    = cnt_q - (q_m_q[8] ? 5'sd0 : 5'sd2) + qm_diff;
        end
    end

    // Stage 2 output and disparity registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            symbol_q <= 10'h354;
            de_s2_q  <= 1'b0;
            cnt_q    <= 5'sd0;
        end else begin
            symbol_q <= symbol_d;
            de_s2_q  <= de_s1_q;
            cnt_q    <= cnt_d;
        end
    end

    assign symbol = symbol_q;
    assign de_q   = de_s2_q;

endmodule
